mem_port_arbiter: RTL

Shares the single unified instruction/data memory port between the multicycle CPU controller path and a debug/loader master (program load, memory dump). Accepts one request at a time per master, sequences a fixed-latency access on the memory port through a small FSM, and returns a one-cycle completion pulse with read data. Sits between the CPU datapath memory mux (IorD output) and the memory macro; the CPU controller stalls its FETCH/LBRD/SBWR states on `cpu_stall_o`.

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/mem_port_arbiter_pick.sv | 35 +++
 rtl/mem_port_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM states, grant encoding and
// the latency counter width.
package mem_port_arbiter_pkg;

  // Transaction sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Which master currently owns the memory port.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_DBG  = 2'd2
  } gnt_e;

  // Wide enough for the largest supported memory latency (15).
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner select for the memory port arbiter.
// With MEM_ARB_ROUND_ROBIN_EN defined, simultaneous requests go to the master
// that was not served last; otherwise the CPU always wins.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic cpu_req_i,
  input  logic dbg_req_i,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  gnt_e last_gnt_i,
`endif
  output logic any_req_o,
  output gnt_e winner_o
);

  assign any_req_o = cpu_req_i | dbg_req_i;

  // Resolve the winner among the pending requests.
  always_comb begin
    // NOTE: assign a default first so every path drives winner_o and no latch is inferred.
    winner_o = GNT_NONE;
    if (cpu_req_i && dbg_req_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      winner_o = (last_gnt_i == GNT_CPU) ? GNT_DBG : GNT_CPU;
`else
      winner_o = GNT_CPU;
`endif
    end else if (cpu_req_i) begin
      winner_o = GNT_CPU;
    end else if (dbg_req_i) begin
      winner_o = GNT_DBG;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the CPU controller and a debug/loader
// master. One transaction at a time: IDLE -> ACCESS -> WAIT -> DONE, with a
// one-cycle done pulse and read data registered from the memory.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration
// (default build: fixed priority, CPU first).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_done_o,
  output logic              cpu_stall_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);

  state_e            state_q;
  gnt_e              gnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rdata_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic              cpu_done_q;
  logic              dbg_done_q;

  logic              any_req;
  gnt_e              winner;
  logic              req_we_d;
  logic [ADDR_W-1:0] req_addr_d;
  logic [DATA_W-1:0] req_wdata_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  gnt_e              last_gnt_q;

  mem_arb_pick u_pick (
    .cpu_req_i  (cpu_req_i),
    .dbg_req_i  (dbg_req_i),
    .last_gnt_i (last_gnt_q),
    .any_req_o  (any_req),
    .winner_o   (winner)
  );

  // Remember who was served last so the other master wins the next tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_q <= GNT_DBG;
    end else if (state_q == ST_DONE) begin
      last_gnt_q <= gnt_q;
    end
  end
`else
  mem_arb_pick u_pick (
    .cpu_req_i (cpu_req_i),
    .dbg_req_i (dbg_req_i),
    .any_req_o (any_req),
    .winner_o  (winner)
  );
`endif

  // Steer the winning master's request fields toward the request latch.
  always_comb begin
    req_we_d    = cpu_we_i;
    req_addr_d  = cpu_addr_i;
    req_wdata_d = cpu_wdata_i;
    if (winner == GNT_DBG) begin
      req_we_d    = dbg_we_i;
      req_addr_d  = dbg_addr_i;
      req_wdata_d = dbg_wdata_i;
    end
  end

  // Transaction sequencer with registered memory strobes and done pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= GNT_NONE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      cpu_done_q <= 1'b0;
      dbg_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      cpu_done_q <= 1'b0;
      dbg_done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            gnt_q    <= winner;
            we_q     <= req_we_d;
            addr_q   <= req_addr_d;
            wdata_q  <= req_wdata_d;
            mem_en_q <= 1'b1;
            mem_we_q <= req_we_d;
            state_q  <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          cnt_q   <= LAT_LOAD;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            if (!we_q) begin
              rdata_q <= mem_rdata_i;
            end
            cpu_done_q <= (gnt_q == GNT_CPU);
            dbg_done_q <= (gnt_q == GNT_DBG);
            state_q    <= ST_DONE;
          end
        end
        ST_DONE: begin
          gnt_q   <= GNT_NONE;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpu_done_o  = cpu_done_q;
  assign dbg_done_o  = dbg_done_q;
  assign rdata_o     = rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign cpu_stall_o = cpu_req_i & ~cpu_done_q;

endmodule
